// File: rtl/seq_scan_pkg.sv
// Shared types for the "101" sequence-scan controller and its detector next-state logic.
package seq_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

   // Detector state encoding {A,B}; 2'b11 is unreachable and treated as illegal.
   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;

endpackage

// File: rtl/seq_scan_if.sv
// Start/busy/done handshake plus scan results between a parent block and seq_scan_ctrl.
interface seq_scan_if #(
   parameter int N = 28
);
   localparam int CW = $clog2(N + 1);

   logic          start;
   logic [N-1:0]  vec;
   logic          busy;
   logic          done;
   logic          X;
   logic          A;
   logic          B;
   logic          hit;
   logic [CW-1:0] count;
   logic [CW-1:0] first_idx;

   modport master (
      output start, vec,
      input  busy, done, X, A, B, hit, count, first_idx
   );

   modport slave (
      input  start, vec,
      output busy, done, X, A, B, hit, count, first_idx
   );

endinterface

// File: rtl/seq_det_next.sv
// Combinational next-state and output logic of the 2-bit Mealy "101" detector (overlapping).
import seq_scan_pkg::*;

module seq_det_next (
   input  logic X,
   input  logic A,
   input  logic B,
   output logic A_star,
   output logic B_star,
   output logic F
);

   always_comb begin
      {A_star, B_star} = S0;
      F                = 1'b0;
      case ({A, B})
         S0: {A_star, B_star} = X ? S1 : S0;
         S1: {A_star, B_star} = X ? S1 : S2;
         S2: begin
            {A_star, B_star} = X ? S1 : S0;
            F                = X;
         end
         default: begin
            {A_star, B_star} = S0;
            F                = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Captures an N-bit stimulus word on start and streams it MSB-first through the "101"
// detector, holding the detector state and reporting hits, hit count and first-hit index.
import seq_scan_pkg::*;

module seq_scan_ctrl #(
   parameter int N = 28
) (
   input  logic    CLK,
   input  logic    RST,
   seq_scan_if.slave bus
);

   localparam int            CW       = $clog2(N + 1);
   localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);
   localparam logic [CW-1:0] NO_HIT   = CW'(N);

   ctrl_state_t   state;
   logic [N-1:0]  shreg;
   logic [CW-1:0] idx;
   logic          a_q;
   logic          b_q;
   logic          hit_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] first_q;

   logic x;
   logic a_star;
   logic b_star;
   logic f_raw;
   logic f;
   logic in_run;

   assign in_run = (state == RUN);

   // Outside RUN the detector sees 0 and its output is masked, so no stray hits.
   assign x = in_run ? shreg[N-1] : 1'b0;
   assign f = in_run & f_raw;

   seq_det_next u_next (
      .X      (x),
      .A      (a_q),
      .B      (b_q),
      .A_star (a_star),
      .B_star (b_star),
      .F      (f_raw)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         shreg   <= '0;
         idx     <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         hit_q   <= 1'b0;
         count_q <= '0;
         first_q <= NO_HIT;
      end else begin
         case (state)
            IDLE: begin
               hit_q <= 1'b0;
               if (bus.start) begin
                  shreg   <= bus.vec;
                  idx     <= '0;
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  count_q <= '0;
                  first_q <= NO_HIT;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_star;
               b_q     <= b_star;
               hit_q   <= f;
               count_q <= count_q + {{(CW-1){1'b0}}, f};
               if (f && (first_q == NO_HIT)) begin
                  first_q <= idx;
               end
               shreg <= {shreg[N-2:0], 1'b0};
               idx   <= idx + CW'(1);
               if (idx == IDX_LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               hit_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = in_run;
   assign bus.done      = (state == DONE);
   assign bus.X         = x;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.hit       = hit_q;
   assign bus.count     = count_q;
   assign bus.first_idx = first_q;

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Scheduler and state holder for the team's 2-bit Mealy "101" sequence detector. It captures an N-bit stimulus word on a start request and streams it one bit per clock into the combinational next-state logic, owning the A/B state flip-flops. It reports per-bit hits, total hit count and first-hit position through a start/busy/done handshake. It replaces hand-sequenced benches and lets a parent block run pattern scans autonomously.

## Interface
- N, default 28: stimulus length in bits, N ≥ 3.
- CW (localparam): $clog2(N+1), width of count and index outputs.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- vec  in  N  stimulus word; bit N-1 is streamed first.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- X  out  1  bit currently presented to the detector.
- A, B  out  1 each  current detector state register.
- hit  out  1  registered detector output F of the previous RUN cycle.
- count  out  CW  number of hits in current/last scan.
- first_idx  out  CW  stream index (0-based) of the first hit; N if none.

## Operation
- Controller FSM: IDLE → RUN → DONE → IDLE.
- IDLE: on start=1, load shift register with vec, idx←0, {A,B}←00, count←0, first_idx←N, hit←0, then go to RUN.
- RUN, each cycle:
  - X = shreg[N-1].
  - {A,B}←{A_star,B_star}.
  - hit←F.
  - count←count+F.
  - If F=1 and first_idx==N, first_idx←idx.
  - Shift shreg left, idx←idx+1.
  - When idx==N-1, go to DONE.
- DONE: done=1 for one cycle; outputs hold; go to IDLE.
- Results (count, first_idx, A, B) hold until the next accepted start.
- Detector encoding: S0=00, S1=01, S2=10.
  - S0: X=1→S1, X=0→S0.
  - S1: X=1→S1, X=0→S2.
  - S2: X=1→S1 with F=1, X=0→S0.
  - 11 is illegal: next state S0, F=0.
- F is asserted only in RUN; it is forced to 0 in IDLE and DONE.
- Detection is overlapping.
- start while busy or during DONE is ignored. There is no queueing.
- vec is sampled only at the accepting edge; later changes to vec have no effect.
- count cannot overflow: at most N-2 hits, and CW holds N.

## Timing
- Reset values: busy=0, done=0, X=0, A=B=0, hit=0, count=0, first_idx=N. FSM in IDLE, shreg=0, idx=0.
- RST asserted mid-scan aborts immediately (asynchronous). No done pulse is produced. The first start after RST deasserts is accepted normally.
- start accepted at edge 0 → busy high in cycles 1..N.
  - Bit k of the stream is on X in cycle k+1.
  - hit for bit k is visible in cycle k+2.
  - done is high in cycle N+1.
- Earliest next start is accepted in cycle N+2, giving a minimum period of N+2 cycles.
- X is driven combinationally from shreg. hit, count, first_idx, A, B are registered.

## Structure
- Shared package seq_scan_pkg holds:
  - Controller state typedef: IDLE, RUN, DONE.
  - Detector state constants S0, S1, S2.
- Sub-module seq_det_next: purely combinational (X, A, B) → (A_star, B_star, F).
  - The controller instantiates it and owns the state flops.
  - It is reusable by existing benches.

## Test plan
- vec=28'b0010101010010101100110101000, start pulse → busy 28 cycles, count=7, first_idx=4, done pulse in cycle 29, hit pulses for stream indices 4, 6, 8, 13, 15, 22, 24.
- vec=28'hAAAAAAA (alternating 10…, MSB first) → count=13, first_idx=2.
- vec=0, then vec=28'hFFFFFFF → count=0 and first_idx=28 for both; final {A,B}=00, then 01.
- start held high for 40 cycles with the first vector → exactly one scan per N+2 cycles; start pulses during RUN/DONE are ignored; results are identical across scans.
- RST pulse in cycle 10 of a scan → all outputs at reset values immediately, no done pulse; a following start yields count=7 for the first vector.
- Force {A,B}=11 via a bench hook into seq_det_next → next state 00, F=0.
